// File: rtl/adc_sequencer.sv
// adc_sequencer: paces conversions of a multiplexed ADC, averages completions
// into output samples and groups samples into bursts.
//
// Optional feature: define ADC_SEQUENCER_OVERRUN_EN to enable sticky overrun
// detection. When it is undefined, overrun is tied low.
//
// Ports:
//   aclk, areset       clock, synchronous active-high reset
//   cfg_divider        conversion period in aclk cycles (0 = no conversions)
//   cfg_averages       conversions per output sample (0 treated as 1)
//   cfg_burst          output samples per acquisition (0 = unlimited)
//   cfg_mode           00 single-shot, 01 continuous, 10 external trigger
//   start, stop        one-cycle acquisition requests (stop wins)
//   ext_trig, busy     asynchronous pins, double-synchronised internally
//   ready              downstream ready, gates conversion starts
//   cnv                one-cycle conversion-start pulse
//   ch_sel             channel for the current conversion
//   trigger, last      output sample complete / final sample of a burst
//   active             high whenever the sequencer is not idle
//   overrun            sticky: a period elapsed with a conversion in flight
module adc_sequencer #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned AVG_W = 16,
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [CNT_W-1:0] cfg_divider,
    input  logic [AVG_W-1:0] cfg_averages,
    input  logic [CNT_W-1:0] cfg_burst,
    input  logic [1:0]       cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             ext_trig,
    input  logic             busy,
    input  logic             ready,
    output logic             cnv,
    output logic [CH_W-1:0]  ch_sel,
    output logic             trigger,
    output logic             last,
    output logic             active,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    state_t state_q, state_d;

    logic             busy_s1_q, busy_s2_q;
    logic             trig_s1_q, trig_s2_q, trig_s3_q;
    logic [CNT_W-1:0] div_q, burst_q;
    logic [AVG_W-1:0] avg_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [AVG_W-1:0] avg_cnt_q, avg_cnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             inflight_q, inflight_d;
    logic             seen_hi_q, seen_hi_d;
    logic             cnv_q, cnv_d;
    logic             trigger_q, trigger_d;
    logic             last_q, last_d;
    logic             active_q, active_d;

    logic             start_ok, trig_rise, div_tick, cnv_fire, completion;
    logic             sample_done, burst_done;
    logic [AVG_W-1:0] avg_lim;

    // Control decode shared by the FSM and the datapath
    assign start_ok    = (state_q == IDLE) && start && !stop;
    assign trig_rise   = trig_s2_q && !trig_s3_q;
    assign div_tick    = (state_q == RUN) && (div_q != '0) && (div_cnt_q == div_q - CNT_W'(1));
    assign cnv_fire    = div_tick && ready && !inflight_q && !stop;
    // Completion is the synchronised falling edge of busy after it was seen high
    assign completion  = inflight_q && seen_hi_q && !busy_s2_q;
    assign avg_lim     = (avg_q == '0) ? AVG_W'(1) : avg_q;
    assign sample_done = (state_q == RUN) && completion && !stop &&
                         (avg_cnt_q + AVG_W'(1) == avg_lim);
    assign burst_done  = sample_done && (burst_q != '0) &&
                         (burst_cnt_q + CNT_W'(1) == burst_q);

    // State register
    always_ff @(posedge aclk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_ok) state_d = (cfg_mode == 2'b10) ? ARMED : RUN;
            ARMED: begin
                if (stop)           state_d = IDLE;
                else if (trig_rise) state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = (inflight_q && !completion) ? DRAIN : IDLE;
                end else if (burst_done) begin
                    case (mode_q)
                        2'b01:   state_d = RUN;
                        2'b10:   state_d = ARMED;
                        default: state_d = IDLE;
                    endcase
                end
            end
            DRAIN: if (completion) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        div_cnt_d   = '0;
        avg_cnt_d   = avg_cnt_q;
        burst_cnt_d = burst_cnt_q;
        ch_d        = ch_q;
        inflight_d  = inflight_q;
        seen_hi_d   = seen_hi_q;
        cnv_d       = cnv_fire;
        trigger_d   = sample_done;
        last_d      = burst_done;
        active_d    = (state_d != IDLE);

        if ((state_q == RUN) && (state_d == RUN) && (div_q != '0))
            div_cnt_d = div_tick ? '0 : div_cnt_q + CNT_W'(1);

        if (cnv_fire) begin
            inflight_d = 1'b1;
            seen_hi_d  = 1'b0;
        end else if (completion) begin
            inflight_d = 1'b0;
            seen_hi_d  = 1'b0;
        end else if (inflight_q && busy_s2_q) begin
            seen_hi_d = 1'b1;
        end

        if ((state_q == RUN) && completion && !stop)
            avg_cnt_d = sample_done ? '0 : avg_cnt_q + AVG_W'(1);

        if (sample_done) begin
            burst_cnt_d = burst_done ? '0 : burst_cnt_q + CNT_W'(1);
            if (burst_done)                    ch_d = '0;
            else if (ch_q == CH_W'(N_CH - 1))  ch_d = '0;
            else                               ch_d = ch_q + CH_W'(1);
        end

        if (state_d == IDLE) begin
            avg_cnt_d   = '0;
            burst_cnt_d = '0;
            ch_d        = '0;
        end
    end

    // Datapath, synchronisers and configuration latch
    always_ff @(posedge aclk) begin
        if (areset) begin
            busy_s1_q   <= 1'b0;
            busy_s2_q   <= 1'b0;
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_s3_q   <= 1'b0;
            div_q       <= '0;
            avg_q       <= '0;
            burst_q     <= '0;
            mode_q      <= 2'b00;
            div_cnt_q   <= '0;
            avg_cnt_q   <= '0;
            burst_cnt_q <= '0;
            ch_q        <= '0;
            inflight_q  <= 1'b0;
            seen_hi_q   <= 1'b0;
            cnv_q       <= 1'b0;
            trigger_q   <= 1'b0;
            last_q      <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            busy_s1_q   <= busy;
            busy_s2_q   <= busy_s1_q;
            trig_s1_q   <= ext_trig;
            trig_s2_q   <= trig_s1_q;
            trig_s3_q   <= trig_s2_q;
            if (start_ok) begin
                div_q   <= cfg_divider;
                avg_q   <= cfg_averages;
                burst_q <= cfg_burst;
                mode_q  <= cfg_mode;
            end
            div_cnt_q   <= div_cnt_d;
            avg_cnt_q   <= avg_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            ch_q        <= ch_d;
            inflight_q  <= inflight_d;
            seen_hi_q   <= seen_hi_d;
            cnv_q       <= cnv_d;
            trigger_q   <= trigger_d;
            last_q      <= last_d;
            active_q    <= active_d;
        end
    end

`ifdef ADC_SEQUENCER_OVERRUN_EN
    logic overrun_q;

    // Sticky flag: a period tick arrived while the ADC was still converting
    always_ff @(posedge aclk) begin
        if (areset)                       overrun_q <= 1'b0;
        else if (start_ok)                overrun_q <= 1'b0;
        else if (div_tick && inflight_q)  overrun_q <= 1'b1;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign cnv     = cnv_q;
    assign ch_sel  = ch_q;
    assign trigger = trigger_q;
    assign last    = last_q;
    assign active  = active_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: directed bench for adc_sequencer with a simple ADC busy
// model and a negedge event monitor recording conversions and triggers.
module tb_adc_sequencer;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned AVG_W = 16;
    localparam int unsigned CH_W  = 2;
`ifdef ADC_SEQUENCER_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic [CNT_W-1:0] cfg_divider = '0;
    logic [AVG_W-1:0] cfg_averages = '0;
    logic [CNT_W-1:0] cfg_burst = '0;
    logic [1:0]       cfg_mode = 2'b00;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             ext_trig = 1'b0;
    logic             busy = 1'b0;
    logic             ready = 1'b1;
    logic             cnv, trigger, last, active, overrun;
    logic [CH_W-1:0]  ch_sel;

    adc_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W), .AVG_W(AVG_W)) dut (
        .aclk(aclk), .areset(areset),
        .cfg_divider(cfg_divider), .cfg_averages(cfg_averages),
        .cfg_burst(cfg_burst), .cfg_mode(cfg_mode),
        .start(start), .stop(stop), .ext_trig(ext_trig),
        .busy(busy), .ready(ready),
        .cnv(cnv), .ch_sel(ch_sel), .trigger(trigger), .last(last),
        .active(active), .overrun(overrun)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;

    // Event monitor
    int cyc = 0, cnv_total = 0, trig_total = 0, last_total = 0, last_at = 0;
    int cnv_t [64];
    int trig_t [64];
    logic [CH_W-1:0] ch_log [64];

    always @(negedge aclk) begin
        cyc++;
        if (cnv === 1'b1) begin
            cnv_t[cnv_total % 64]  = cyc;
            ch_log[cnv_total % 64] = ch_sel;
            cnv_total++;
        end
        if (trigger === 1'b1) begin
            trig_t[trig_total % 64] = cyc;
            trig_total++;
            if (last === 1'b1) begin
                last_total++;
                last_at = trig_total;
            end
        end
    end

    // ADC model: busy rises right after cnv and stays high busy_len cycles
    int busy_len = 5;
    int busy_cnt = 0;
    always @(negedge aclk) begin
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) busy = 1'b0;
        end else if (cnv === 1'b1) begin
            busy     = 1'b1;
            busy_cnt = busy_len;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic set_cfg(input int div, input int avg, input int burst, input logic [1:0] mode);
        cfg_divider  = CNT_W'(div);
        cfg_averages = AVG_W'(avg);
        cfg_burst    = CNT_W'(burst);
        cfg_mode     = mode;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        step(3);
        total++; if (cnv !== 1'b0)     begin bad++; $display("FAIL reset_cnv: got %b want 0", cnv); end
        total++; if (ch_sel !== 2'd0)  begin bad++; $display("FAIL reset_ch_sel: got %0d want 0", ch_sel); end
        total++; if (trigger !== 1'b0) begin bad++; $display("FAIL reset_trigger: got %b want 0", trigger); end
        total++; if (last !== 1'b0)    begin bad++; $display("FAIL reset_last: got %b want 0", last); end
        total++; if (active !== 1'b0)  begin bad++; $display("FAIL reset_active: got %b want 0", active); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        areset = 1'b0;
        step(2);
        total++; if (active !== 1'b0)  begin bad++; $display("FAIL idle_after_reset: active %b want 0", active); end
    endtask

    task automatic test_single_shot();
        int cb, tb0, lb;
        set_cfg(10, 1, 4, 2'b00);
        busy_len = 5;
        cb = cnv_total; tb0 = trig_total; lb = last_total;
        pulse_start();
        cfg_divider = CNT_W'(3);  // must be ignored once started
        step(80);
        total++; if (cnv_total - cb != 4) begin bad++; $display("FAIL single_cnv_count: got %0d want 4", cnv_total - cb); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (cnv_t[(cb+i+1)%64] - cnv_t[(cb+i)%64] != 10) begin
                bad++; $display("FAIL single_cnv_spacing[%0d]: got %0d want 10", i, cnv_t[(cb+i+1)%64] - cnv_t[(cb+i)%64]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ch_log[(cb+i)%64] !== 2'(i)) begin
                bad++; $display("FAIL single_ch_sel[%0d]: got %0d want %0d", i, ch_log[(cb+i)%64], i);
            end
        end
        total++; if (trig_total - tb0 != 4) begin bad++; $display("FAIL single_trig_count: got %0d want 4", trig_total - tb0); end
        total++; if (last_total - lb != 1) begin bad++; $display("FAIL single_last_count: got %0d want 1", last_total - lb); end
        total++; if (last_at != tb0 + 4) begin bad++; $display("FAIL single_last_pos: got %0d want %0d", last_at, tb0 + 4); end
        total++; if (trig_t[tb0%64] - cnv_t[cb%64] != 8) begin bad++; $display("FAIL single_trig_latency: got %0d want 8", trig_t[tb0%64] - cnv_t[cb%64]); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL single_end_idle: active %b want 0", active); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL single_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_averaging();
        int cb, tb0, lb;
        set_cfg(10, 3, 2, 2'b00);
        cb = cnv_total; tb0 = trig_total; lb = last_total;
        pulse_start();
        step(90);
        total++; if (cnv_total - cb != 6) begin bad++; $display("FAIL avg_cnv_count: got %0d want 6", cnv_total - cb); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (ch_log[(cb+i)%64] !== 2'(i / 3)) begin
                bad++; $display("FAIL avg_ch_sel[%0d]: got %0d want %0d", i, ch_log[(cb+i)%64], i / 3);
            end
        end
        total++; if (trig_total - tb0 != 2) begin bad++; $display("FAIL avg_trig_count: got %0d want 2", trig_total - tb0); end
        total++; if (trig_t[tb0%64] - cnv_t[(cb+2)%64] != 8) begin bad++; $display("FAIL avg_trig1_pos: got %0d want 8", trig_t[tb0%64] - cnv_t[(cb+2)%64]); end
        total++; if (trig_t[(tb0+1)%64] - cnv_t[(cb+5)%64] != 8) begin bad++; $display("FAIL avg_trig2_pos: got %0d want 8", trig_t[(tb0+1)%64] - cnv_t[(cb+5)%64]); end
        total++; if (last_total - lb != 1) begin bad++; $display("FAIL avg_last_count: got %0d want 1", last_total - lb); end
        total++; if (last_at != tb0 + 2) begin bad++; $display("FAIL avg_last_pos: got %0d want %0d", last_at, tb0 + 2); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL avg_end_idle: active %b want 0", active); end
    endtask

    task automatic test_overrun();
        int cb, tb0;
        set_cfg(3, 1, 2, 2'b00);
        busy_len = 8;
        cb = cnv_total; tb0 = trig_total;
        pulse_start();
        step(50);
        total++; if (cnv_total - cb != 2) begin bad++; $display("FAIL ovr_cnv_count: got %0d want 2", cnv_total - cb); end
        total++; if (cnv_t[(cb+1)%64] - cnv_t[cb%64] != 12) begin bad++; $display("FAIL ovr_cnv_spacing: got %0d want 12", cnv_t[(cb+1)%64] - cnv_t[cb%64]); end
        total++; if (trig_total - tb0 != 2) begin bad++; $display("FAIL ovr_trig_count: got %0d want 2", trig_total - tb0); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL ovr_end_idle: active %b want 0", active); end
        total++; if (overrun !== OVR_EXP) begin bad++; $display("FAIL ovr_sticky: got %b want %b", overrun, OVR_EXP); end
        busy_len = 5;
        // A new start clears the flag; divider 0 issues no conversions
        set_cfg(0, 1, 0, 2'b01);
        cb = cnv_total;
        pulse_start();
        step(3);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear_on_start: got %b want 0", overrun); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL div0_active: got %b want 1", active); end
        step(20);
        total++; if (cnv_total - cb != 0) begin bad++; $display("FAIL div0_no_cnv: got %0d want 0", cnv_total - cb); end
        pulse_stop();
        step(2);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL div0_stop_idle: active %b want 0", active); end
    endtask

    task automatic test_ext_trigger();
        int cb, tb0, lb;
        set_cfg(10, 1, 2, 2'b10);
        ext_trig = 1'b0;
        cb = cnv_total; tb0 = trig_total; lb = last_total;
        pulse_start();
        step(30);
        total++; if (cnv_total - cb != 0) begin bad++; $display("FAIL ext_armed_no_cnv: got %0d want 0", cnv_total - cb); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL ext_armed_active: got %b want 1", active); end
        ext_trig = 1'b1;
        step(40);
        total++; if (cnv_total - cb != 2) begin bad++; $display("FAIL ext_burst1_cnv: got %0d want 2", cnv_total - cb); end
        total++; if (trig_total - tb0 != 2) begin bad++; $display("FAIL ext_burst1_trig: got %0d want 2", trig_total - tb0); end
        total++; if (last_total - lb != 1) begin bad++; $display("FAIL ext_burst1_last: got %0d want 1", last_total - lb); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL ext_rearmed_active: got %b want 1", active); end
        step(20);
        total++; if (cnv_total - cb != 2) begin bad++; $display("FAIL ext_level_no_retrig: got %0d want 2", cnv_total - cb); end
        ext_trig = 1'b0;
        step(5);
        ext_trig = 1'b1;
        step(40);
        total++; if (cnv_total - cb != 4) begin bad++; $display("FAIL ext_burst2_cnv: got %0d want 4", cnv_total - cb); end
        total++; if (trig_total - tb0 != 4) begin bad++; $display("FAIL ext_burst2_trig: got %0d want 4", trig_total - tb0); end
        total++; if (last_total - lb != 2) begin bad++; $display("FAIL ext_burst2_last: got %0d want 2", last_total - lb); end
        pulse_stop();
        step(2);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL ext_stop_idle: active %b want 0", active); end
        ext_trig = 1'b0;
    endtask

    task automatic test_drain();
        int cb, tb0, lb, n, tw;
        set_cfg(10, 1, 0, 2'b01);
        cb = cnv_total; tb0 = trig_total; lb = last_total;
        pulse_start();
        n = 0;
        for (int i = 0; i < 200 && n < 5; i++) begin
            @(negedge aclk);
            if (cnv === 1'b1) n++;
        end
        total++; if (n != 5) begin bad++; $display("FAIL drain_wait_cnv: got %0d want 5", n); end
        pulse_stop();
        tw = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (trigger === 1'b1) tw++;
        end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL drain_active_before_done: got %b want 1", active); end
        step(1);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL drain_active_after_done: got %b want 0", active); end
        total++; if (tw != 0) begin bad++; $display("FAIL drain_window_trig: got %0d want 0", tw); end
        step(10);
        total++; if (trig_total - tb0 != 4) begin bad++; $display("FAIL drain_trig_count: got %0d want 4", trig_total - tb0); end
        total++; if (cnv_total - cb != 5) begin bad++; $display("FAIL drain_cnv_count: got %0d want 5", cnv_total - cb); end
        total++; if (last_total - lb != 0) begin bad++; $display("FAIL drain_no_last: got %0d want 0", last_total - lb); end
        total++; if (ch_log[(cb+3)%64] !== 2'd3) begin bad++; $display("FAIL drain_ch4: got %0d want 3", ch_log[(cb+3)%64]); end
        total++; if (ch_log[(cb+4)%64] !== 2'd0) begin bad++; $display("FAIL drain_ch_wrap: got %0d want 0", ch_log[(cb+4)%64]); end
    endtask

    task automatic test_reset_mid();
        int n, tr, lr, cr;
        set_cfg(10, 1, 4, 2'b00);
        pulse_start();
        n = 0;
        for (int i = 0; i < 100 && n < 2; i++) begin
            @(negedge aclk);
            if (cnv === 1'b1) n++;
        end
        total++; if (n != 2) begin bad++; $display("FAIL rstmid_wait_cnv: got %0d want 2", n); end
        step(2);
        areset = 1'b1;
        step(2);
        areset = 1'b0;
        tr = trig_total; lr = last_total; cr = cnv_total;
        step(20);
        total++; if (trig_total - tr != 0) begin bad++; $display("FAIL rstmid_no_trig: got %0d want 0", trig_total - tr); end
        total++; if (cnv_total - cr != 0) begin bad++; $display("FAIL rstmid_no_cnv: got %0d want 0", cnv_total - cr); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rstmid_active: got %b want 0", active); end
        total++; if (ch_sel !== 2'd0) begin bad++; $display("FAIL rstmid_ch_sel: got %0d want 0", ch_sel); end
        total++; if ({cnv, trigger, last, overrun} !== 4'b0000) begin bad++; $display("FAIL rstmid_outputs: got %b want 0000", {cnv, trigger, last, overrun}); end
        set_cfg(10, 1, 1, 2'b00);
        pulse_start();
        n = 0;
        for (int i = 0; i < 50 && n < 1; i++) begin
            @(negedge aclk);
            if (cnv === 1'b1) begin
                n++;
                total++; if (ch_sel !== 2'd0) begin bad++; $display("FAIL rstmid_restart_ch: got %0d want 0", ch_sel); end
            end
        end
        total++; if (n != 1) begin bad++; $display("FAIL rstmid_restart_cnv: got %0d want 1", n); end
        step(15);
        total++; if (trig_total - tr != 1) begin bad++; $display("FAIL rstmid_restart_trig: got %0d want 1", trig_total - tr); end
        total++; if (last_total - lr != 1) begin bad++; $display("FAIL rstmid_restart_last: got %0d want 1", last_total - lr); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rstmid_restart_idle: active %b want 0", active); end
    endtask

    task automatic test_start_stop_ready();
        int cb, tb0;
        set_cfg(10, 1, 1, 2'b00);
        cb = cnv_total;
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        step(3);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL start_stop_same: active %b want 0", active); end
        step(12);
        total++; if (cnv_total - cb != 0) begin bad++; $display("FAIL start_stop_no_cnv: got %0d want 0", cnv_total - cb); end
        // Ticks while ready is low are skipped
        ready = 1'b0;
        tb0 = trig_total;
        pulse_start();
        step(30);
        total++; if (cnv_total - cb != 0) begin bad++; $display("FAIL ready_low_no_cnv: got %0d want 0", cnv_total - cb); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL ready_low_active: got %b want 1", active); end
        ready = 1'b1;
        step(25);
        total++; if (cnv_total - cb != 1) begin bad++; $display("FAIL ready_high_cnv: got %0d want 1", cnv_total - cb); end
        total++; if (trig_total - tb0 != 1) begin bad++; $display("FAIL ready_high_trig: got %0d want 1", trig_total - tb0); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL ready_high_idle: active %b want 0", active); end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_averaging();
        test_overrun();
        test_ext_trigger();
        test_drain();
        test_reset_mid();
        test_start_stop_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
